// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Closes the loop around the ADC-timing PLL. It holds the PLL in reset for a
// fixed pulse, waits for lock, requires lock to stay up for a stable window,
// and only then releases the system reset. A loss of lock while running
// re-arms the PLL. Repeated lock timeouts latch a fault that software clears.
// Everything runs on the PLL reference clock, so the supervisor keeps working
// while the PLL output clocks are down.
//
// Ports
//   refclk       in   reference clock; the only clock
//   rst          in   asynchronous active-high reset
//   pll_locked   in   PLL lock indicator; asynchronous; 2-FF synchronised here
//   clear_fault  in   single-cycle pulse; leaves FAULT, ignored elsewhere
//   pll_rst      out  reset to the PLL, active high
//   sys_rst      out  system reset, active high
//   ready        out  PLL locked and stable (always ~sys_rst)
//   fault        out  lock could not be obtained within MAX_RETRIES attempts
//   retry_cnt    out  failed attempts in the current acquisition
//   lol_cnt      out  loss-of-lock events seen while running; saturates at 255
//
// Build option
//   LOCK_GLITCH_FILTER_EN  when defined, a loss of lock while running is only
//                          acted on after 4 consecutive unlocked cycles.
//                          When undefined, a single unlocked cycle counts.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int LOCK_TIMEOUT     = 327680,
   parameter int STABLE_CYCLES    = 32768,
   parameter int MAX_RETRIES      = 3,
   parameter int CNT_W            = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clear_fault,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lol_cnt
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   // Terminal counts are compared against the value the counter holds on the
   // edge that should cause the transition, hence the "-1".
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);
`ifdef LOCK_GLITCH_FILTER_EN
   localparam logic [CNT_W-1:0] LOL_LAST  = CNT_W'(3);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       lol_q, lol_d;
   logic             sync1_q, sync2_q;
   logic             locked_s;
   logic             lol_event;
   logic [3:0]       retry_inc;
   logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

   // Two-flop synchroniser for the asynchronous lock indicator.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
      end
   end

   assign locked_s  = sync2_q;
   assign retry_inc = retry_q + 4'd1;

   // A loss of lock in RUN is either any unlocked cycle, or, with the glitch
   // filter, the fourth consecutive one. In the filtered build the shared
   // counter tracks the run of unlocked cycles while in RUN.
`ifdef LOCK_GLITCH_FILTER_EN
   assign lol_event = !locked_s && (cnt_q == LOL_LAST);
`else
   assign lol_event = !locked_s;
`endif

   // Next-state, counter and statistics logic. Lock beats timeout when both
   // happen on the same edge because the locked test is evaluated first.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lol_d   = lol_q;
      cnt_d   = cnt_q + CNT_W'(1);

      case (state_q)
         RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == TMO_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? FAULT : RESET_PLL;
            end
         end
         STABILIZE: begin
            // A flicker drops back to waiting without charging a retry; the
            // counter clear on the state change restarts the timeout window.
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               retry_d = 4'd0;
            end
         end
         RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
            cnt_d = locked_s ? '0 : cnt_q + CNT_W'(1);
`else
            cnt_d = '0;
`endif
            if (lol_event) begin
               state_d = RESET_PLL;
               if (lol_q != 8'hFF) begin
                  lol_d = lol_q + 8'd1;
               end
            end
         end
         FAULT: begin
            cnt_d = cnt_q;
            if (clear_fault) begin
               state_d = RESET_PLL;
               retry_d = 4'd0;
            end
         end
         default: begin
            state_d = RESET_PLL;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   // State, counter and statistics registers.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_PLL;
         cnt_q   <= '0;
         retry_q <= 4'd0;
         lol_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         lol_q   <= lol_d;
      end
   end

   // Outputs are decoded from the next state and registered, so they track
   // state_q exactly while staying glitch-free at the pins.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
         sys_rst_q <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
         fault_q   <= (state_d == FAULT);
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign lol_cnt   = lol_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor with small timing parameters.
// Each stimulus step pushes the outputs it should cause, stamped with the
// refclk edge count at which they are due, into a scoreboard queue. A monitor
// on the falling edge pops due entries and compares them against the DUT.
// Honors LOCK_GLITCH_FILTER_EN for the loss-of-lock scenarios.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   localparam int RST_P = 4;
   localparam int TMO   = 20;
   localparam int STB   = 8;
   localparam int MAXR  = 2;

`ifdef LOCK_GLITCH_FILTER_EN
   localparam int DROP_LEN = 4;
   localparam int LOL_LAT  = 6;
`else
   localparam int DROP_LEN = 1;
   localparam int LOL_LAT  = 3;
`endif

   // Edges from a loss-of-lock until ready returns: detect, reset pulse,
   // one edge to see lock in WAIT_LOCK, then the stable window.
   localparam int RELOCK_LAT = LOL_LAT + RST_P + 1 + STB;

   localparam int SEL_PLLRST = 0;
   localparam int SEL_SYSRST = 1;
   localparam int SEL_READY  = 2;
   localparam int SEL_FAULT  = 3;
   localparam int SEL_RETRY  = 4;
   localparam int SEL_LOL    = 5;

   typedef struct {
      int    due;
      int    sel;
      int    val;
      string tag;
   } expect_t;

   logic       refclk;
   logic       rst;
   logic       pllLocked;
   logic       clearFault;
   logic       pllRst;
   logic       sysRst;
   logic       ready;
   logic       fault;
   logic [3:0] retryCnt;
   logic [7:0] lolCnt;

   expect_t sbQueue[$];
   int      cyc         = 0;
   int      totalChecks = 0;
   int      badChecks   = 0;

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES(RST_P),
      .LOCK_TIMEOUT    (TMO),
      .STABLE_CYCLES   (STB),
      .MAX_RETRIES     (MAXR),
      .CNT_W           (20)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pllLocked),
      .clear_fault(clearFault),
      .pll_rst    (pllRst),
      .sys_rst    (sysRst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retryCnt),
      .lol_cnt    (lolCnt)
   );

   // Reference clock, 10 time units per period.
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Rising-edge count used to time-stamp scoreboard entries.
   always @(posedge refclk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed != expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic int observe(input int sel);
      case (sel)
         SEL_PLLRST: return int'(pllRst);
         SEL_SYSRST: return int'(sysRst);
         SEL_READY:  return int'(ready);
         SEL_FAULT:  return int'(fault);
         SEL_RETRY:  return int'(retryCnt);
         SEL_LOL:    return int'(lolCnt);
         default:    return -1;
      endcase
   endfunction

   // Queue an expectation for the output selected by sel, due dt edges from now.
   task automatic expectAt(input string tag, input int sel, input int dt, input int val);
      expect_t e;
      e.due = cyc + dt;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      sbQueue.push_back(e);
   endtask

   // Scoreboard consumer: compare every entry that falls due after this edge.
   always @(negedge refclk) begin
      for (int i = sbQueue.size() - 1; i >= 0; i--) begin
         if (sbQueue[i].due == cyc) begin
            checkOutput(sbQueue[i].tag, observe(sbQueue[i].sel), sbQueue[i].val);
            sbQueue.delete(i);
         end
      end
   end

   task automatic applyStimulus(input logic locked, input logic clr);
      pllLocked  = locked;
      clearFault = clr;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge refclk);
   endtask

   // Assert reset between edges, check the reset state before any edge, then
   // release it on a falling edge with the PLL unlocked.
   task automatic doReset(input string tag);
      @(negedge refclk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput({tag, "_pllrst"}, int'(pllRst), 1);
      checkOutput({tag, "_sysrst"}, int'(sysRst), 1);
      checkOutput({tag, "_ready"}, int'(ready), 0);
      checkOutput({tag, "_fault"}, int'(fault), 0);
      checkOutput({tag, "_retry"}, int'(retryCnt), 0);
      checkOutput({tag, "_lol"}, int'(lolCnt), 0);
      @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      pllLocked  = 1'b0;
      clearFault = 1'b0;

      // Bring-up: 4-cycle PLL reset pulse, lock 5 cycles later, ready 11 edges on.
      doReset("t1_rst");
      expectAt("t1_pllrst_hi", SEL_PLLRST, RST_P - 1, 1);
      expectAt("t1_pllrst_lo", SEL_PLLRST, RST_P, 0);
      waitCycles(RST_P + 5);
      applyStimulus(1'b1, 1'b0);
      expectAt("t1_ready_early", SEL_READY, STB + 2, 0);
      expectAt("t1_ready", SEL_READY, STB + 3, 1);
      expectAt("t1_sysrst", SEL_SYSRST, STB + 3, 0);
      expectAt("t1_retry", SEL_RETRY, STB + 3, 0);
      waitCycles(STB + 6);

      // clear_fault outside FAULT must be ignored.
      applyStimulus(1'b1, 1'b1);
      expectAt("t1_clr_ready", SEL_READY, 2, 1);
      expectAt("t1_clr_fault", SEL_FAULT, 2, 0);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(3);

`ifdef LOCK_GLITCH_FILTER_EN
      // Drops of 1..3 cycles are filtered out while running.
      for (int w = 1; w <= 3; w++) begin
         applyStimulus(1'b0, 1'b0);
         expectAt("t4_short_ready", SEL_READY, w + 3, 1);
         expectAt("t4_short_lol", SEL_LOL, w + 4, 0);
         waitCycles(w);
         applyStimulus(1'b1, 1'b0);
         waitCycles(8);
      end
`endif

      // Loss of lock in RUN.
      applyStimulus(1'b0, 1'b0);
      expectAt("t4_ready_hold", SEL_READY, LOL_LAT - 1, 1);
      expectAt("t4_ready_fall", SEL_READY, LOL_LAT, 0);
      expectAt("t4_sysrst", SEL_SYSRST, LOL_LAT, 1);
      expectAt("t4_lol", SEL_LOL, LOL_LAT, 1);
      expectAt("t4_pllrst_hi", SEL_PLLRST, LOL_LAT + RST_P - 1, 1);
      expectAt("t4_pllrst_lo", SEL_PLLRST, LOL_LAT + RST_P, 0);
      expectAt("t4_relock_early", SEL_READY, RELOCK_LAT - 1, 0);
      expectAt("t4_relock", SEL_READY, RELOCK_LAT, 1);
      waitCycles(DROP_LEN);
      applyStimulus(1'b1, 1'b0);
      waitCycles(RELOCK_LAT + 2 - DROP_LEN);

      // Drive the loss-of-lock counter into saturation.
      for (int n = 2; n <= 257; n++) begin
         applyStimulus(1'b0, 1'b0);
         expectAt("sat_lol", SEL_LOL, LOL_LAT, (n > 255) ? 255 : n);
         expectAt("sat_ready", SEL_READY, RELOCK_LAT, 1);
         waitCycles(DROP_LEN);
         applyStimulus(1'b1, 1'b0);
         waitCycles(RELOCK_LAT + 2 - DROP_LEN);
      end

      // Async reset mid-RUN: all outputs return to reset values before an edge.
      checkOutput("t6_pre_ready", int'(ready), 1);
      checkOutput("t6_pre_lol", int'(lolCnt), 255);
      doReset("t6_rst");

      // Timeout to fault with the PLL never locking.
      expectAt("t2_pllrst_hi1", SEL_PLLRST, RST_P - 1, 1);
      expectAt("t2_pllrst_lo1", SEL_PLLRST, RST_P, 0);
      expectAt("t2_window1_end", SEL_PLLRST, RST_P + TMO - 1, 0);
      expectAt("t2_pllrst_hi2", SEL_PLLRST, RST_P + TMO, 1);
      expectAt("t2_retry1", SEL_RETRY, RST_P + TMO, 1);
      expectAt("t2_pllrst_hi2_end", SEL_PLLRST, 2 * RST_P + TMO - 1, 1);
      expectAt("t2_pllrst_lo2", SEL_PLLRST, 2 * RST_P + TMO, 0);
      expectAt("t2_window2_end", SEL_PLLRST, 2 * (RST_P + TMO) - 1, 0);
      expectAt("t2_fault_early", SEL_FAULT, 2 * (RST_P + TMO) - 1, 0);
      expectAt("t2_fault", SEL_FAULT, 2 * (RST_P + TMO), 1);
      expectAt("t2_fault_pllrst", SEL_PLLRST, 2 * (RST_P + TMO), 1);
      expectAt("t2_retry2", SEL_RETRY, 2 * (RST_P + TMO), MAXR);
      expectAt("t2_sysrst", SEL_SYSRST, 2 * (RST_P + TMO), 1);
      expectAt("t2_fault_hold", SEL_FAULT, 2 * (RST_P + TMO) + 9, 1);
      expectAt("t2_retry_hold", SEL_RETRY, 2 * (RST_P + TMO) + 9, MAXR);
      waitCycles(2 * (RST_P + TMO) + 10);

      // Fault recovery: clear the fault while the PLL reports lock.
      applyStimulus(1'b1, 1'b1);
      expectAt("t3_fault_clr", SEL_FAULT, 1, 0);
      expectAt("t3_retry_clr", SEL_RETRY, 1, 0);
      expectAt("t3_pllrst_hi", SEL_PLLRST, RST_P, 1);
      expectAt("t3_pllrst_lo", SEL_PLLRST, RST_P + 1, 0);
      expectAt("t3_ready_early", SEL_READY, RST_P + 1 + STB, 0);
      expectAt("t3_ready", SEL_READY, RST_P + 2 + STB, 1);
      expectAt("t3_retry_run", SEL_RETRY, RST_P + 2 + STB, 0);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(RST_P + STB + 4);

      // Flicker during STABILIZE restarts the stable window without a retry.
      doReset("t5_rst");
      waitCycles(RST_P + 1);
      applyStimulus(1'b1, 1'b0);
      expectAt("t5_pllrst", SEL_PLLRST, 9, 0);
      expectAt("t5_retry_mid", SEL_RETRY, 9, 0);
      expectAt("t5_no_early", SEL_READY, STB + 3, 0);
      expectAt("t5_ready_early", SEL_READY, STB + 8, 0);
      expectAt("t5_ready", SEL_READY, STB + 9, 1);
      expectAt("t5_retry", SEL_RETRY, STB + 9, 0);
      waitCycles(5);
      applyStimulus(1'b0, 1'b0);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(STB + 6);

      // Lock seen on the very edge the timeout expires: lock wins.
      doReset("t7_rst");
      waitCycles(RST_P + TMO - 3);
      applyStimulus(1'b1, 1'b0);
      expectAt("t7_pllrst", SEL_PLLRST, 3, 0);
      expectAt("t7_pllrst_after", SEL_PLLRST, 4, 0);
      expectAt("t7_retry", SEL_RETRY, 4, 0);
      expectAt("t7_ready_early", SEL_READY, STB + 2, 0);
      expectAt("t7_ready", SEL_READY, STB + 3, 1);
      waitCycles(STB + 6);

      checkOutput("sb_drained", sbQueue.size(), 0);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
